clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog_if.sv | 22 ++
 rtl/clk_div_prog.sv | 77 +++++++
 tb/tb_clk_div_prog.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Control and status bundle of the programmable clock divider: run enable,
// divisor write port, and the BUSY/TICK/CLKout results.
interface clk_div_prog_if #(
  parameter int W = 16
);
  logic         EN;
  logic [W-1:0] DIVin;
  logic         DIVwr;
  logic         BUSY;
  logic         TICK;
  logic         CLKout;

  modport master (
    output EN, DIVin, DIVwr,
    input  BUSY, TICK, CLKout
  );

  modport slave (
    input  EN, DIVin, DIVwr,
    output BUSY, TICK, CLKout
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider (ratio DIV+1) with a registered sample strobe.
// A new divisor only takes effect at a period boundary or while the divider is idle.
module clk_div_prog #(
  parameter int           W        = 16,
  parameter logic [W-1:0] DIV_INIT = '0
) (
  input logic          CLKin,
  input logic          RSTn,
  clk_div_prog_if.slave bus
);

  logic [W-1:0] cnt, cur, pend;
  logic         busy, tick, clkout;

  logic         wrap, apply;
  logic [W-1:0] cnt_nxt, cur_nxt, pend_nxt;
  logic         busy_nxt, clk_nxt;
  logic [W:0]   half;

  // ceil((d+1)/2), one bit wider so an all-ones divisor cannot overflow
  function automatic logic [W:0] half_up(input logic [W-1:0] d);
    logic [W:0] s;
    s = {1'b0, d} + (W+1)'(2);
    return s >> 1;
  endfunction

  always_comb begin
    wrap     = bus.EN && (cnt == cur);
    apply    = wrap || !bus.EN;
    cnt_nxt  = '0;
    cur_nxt  = cur;
    pend_nxt = pend;
    busy_nxt = busy;

    if (bus.EN && !wrap) begin
      cnt_nxt = cnt + W'(1);
    end

    // A write landing on an apply edge bypasses pend; otherwise it waits there.
    if (apply && bus.DIVwr) begin
      cur_nxt  = bus.DIVin;
      busy_nxt = 1'b0;
    end else if (apply && busy) begin
      cur_nxt  = pend;
      busy_nxt = 1'b0;
    end else if (bus.DIVwr) begin
      pend_nxt = bus.DIVin;
      busy_nxt = 1'b1;
    end

    half    = half_up(cur);
    clk_nxt = bus.EN && ({1'b0, cnt_nxt} < half);
  end

  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      cnt    <= '0;
      cur    <= DIV_INIT;
      pend   <= '0;
      busy   <= 1'b0;
      tick   <= 1'b0;
      clkout <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      cur    <= cur_nxt;
      pend   <= pend_nxt;
      busy   <= busy_nxt;
      tick   <= wrap;
      clkout <= clk_nxt;
    end
  end

  assign bus.BUSY   = busy;
  assign bus.TICK   = tick;
  assign bus.CLKout = clkout;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog (W=4, DIV_INIT=3): a driver feeds directed and
// random stimulus to a period-level model, a negedge monitor compares the DUT.
module tb_clk_div_prog;

  localparam int W = 4;

  typedef struct {
    int   cyc;
    logic tick;
    logic clk;
    logic busy;
  } exp_t;

  logic CLKin = 1'b0;
  logic RSTn  = 1'b0;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  exp_t sb[$];

  // period-level model: ratio R, position inside the current period, pending write
  int   ratio  = 4;
  int   pos    = 0;
  int   pend_m = 0;
  bit   busy_m = 1'b0;
  bit   tick_m = 1'b0;
  bit   clk_m  = 1'b0;

  clk_div_prog_if #(.W(W)) bus_if ();

  clk_div_prog #(.W(W), .DIV_INIT(4'd3)) dut (
    .CLKin (CLKin),
    .RSTn  (RSTn),
    .bus   (bus_if)
  );

  always #5 CLKin = ~CLKin;
  always @(posedge CLKin) cyc_cnt <= cyc_cnt + 1;

  initial begin
    bus_if.EN    = 1'b0;
    bus_if.DIVwr = 1'b0;
    bus_if.DIVin = '0;
  end

  task automatic chk(input string nm, input int cyc, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0b want=%0b", nm, cyc, got, want);
    end
  endtask

  always @(negedge CLKin) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_entry cycle=%0d got=unchecked want=checked", e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      e = sb.pop_front();
      chk("TICK",   e.cyc, bus_if.TICK,   e.tick);
      chk("CLKout", e.cyc, bus_if.CLKout, e.clk);
      chk("BUSY",   e.cyc, bus_if.BUSY,   e.busy);
    end
  end

  // One clock of stimulus: drive just after a rising edge, predict the next edge.
  task automatic step(input bit rstv, input bit en, input bit wr, input logic [W-1:0] din);
    exp_t e;
    if (!rstv && RSTn) begin
      // asynchronous reset: outputs must already be low before the next edge
      if (sb.size() > 0) e = sb.pop_back();
      e.cyc = cyc_cnt; e.tick = 1'b0; e.clk = 1'b0; e.busy = 1'b0;
      sb.push_back(e);
    end
    RSTn         = rstv;
    bus_if.EN    = en;
    bus_if.DIVwr = wr;
    bus_if.DIVin = din;

    if (!rstv) begin
      ratio = 4; pos = 0; pend_m = 0; busy_m = 1'b0; tick_m = 1'b0; clk_m = 1'b0;
    end else if (!en) begin
      if (wr) ratio = int'(din) + 1;
      else if (busy_m) ratio = pend_m + 1;
      busy_m = 1'b0; pos = 0; tick_m = 1'b0; clk_m = 1'b0;
    end else begin
      if (pos == ratio - 1) begin
        tick_m = 1'b1;
        pos    = 0;
        if (wr) ratio = int'(din) + 1;
        else if (busy_m) ratio = pend_m + 1;
        busy_m = 1'b0;
      end else begin
        tick_m = 1'b0;
        pos++;
        if (wr) begin
          pend_m = int'(din);
          busy_m = 1'b1;
        end
      end
      clk_m = (pos < (ratio + 1) / 2);
    end

    e.cyc = cyc_cnt + 1; e.tick = tick_m; e.clk = clk_m; e.busy = busy_m;
    sb.push_back(e);
    @(posedge CLKin);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic run_to_last(); // stop where the next edge ends the period
    for (int i = 0; i < 20 && pos != ratio - 1; i++) step(1'b1, 1'b1, 1'b0, '0);
  endtask

  initial begin
    @(posedge CLKin);
    #1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    // ratio 4 from reset
    run(14);
    // mid-period write of 4
    run_to_last();
    run(1);
    step(1'b1, 1'b1, 1'b1, 4'd4);
    run(16);
    // two writes in one period, last wins
    run_to_last();
    run(1);
    step(1'b1, 1'b1, 1'b1, 4'd6);
    step(1'b1, 1'b1, 1'b1, 4'd2);
    run(12);
    // ratio 1, then idle
    step(1'b1, 1'b1, 1'b1, 4'd0);
    run(8);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    // all-ones divisor written while idle
    step(1'b1, 1'b0, 1'b1, 4'hF);
    run(36);
    // write coinciding with the wrap
    run_to_last();
    step(1'b1, 1'b1, 1'b1, 4'd2);
    run(9);
    // pending write then EN low applies it
    step(1'b1, 1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b0, 1'b0, '0);
    run(14);
    // reset mid-period with a pending write
    step(1'b1, 1'b1, 1'b1, 4'd9);
    run(1);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    run(12);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(9) != 0),
           ($urandom_range(6) == 0), W'($urandom));
    end
    run(4);
    repeat (2) @(negedge CLKin);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending entries", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
